// File: rtl/seg7_pkg.sv
// Shared seven-segment constants (active-low {g,f,e,d,c,b,a}) and a counter
// width helper used by the scanner and its decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Display bus between the digit/value source (master) and the scanner (slave).
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  // No handshake: every signal is a level, sampled by the scanner on each
  // rising clock edge; outputs are registered and valid every cycle.
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lz;
  logic                    enable;
  logic [NUM_DIGITS-1:0]   DIGIT;
  logic [6:0]              DISPLAY_OUT;
  logic                    DP_OUT;
  logic                    scan_tick;

  modport master (
    output value, dp_mask, blank_lz, enable,
    input  DIGIT, DISPLAY_OUT, DP_OUT, scan_tick
  );

  modport slave (
    input  value, dp_mask, blank_lz, enable,
    output DIGIT, DISPLAY_OUT, DP_OUT, scan_tick
  );
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-segment decoder; codes above 9 decode only in hex mode.
module seg7_hex_decoder
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] code_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  logic [6:0] hex_a, hex_b, hex_c, hex_d, hex_e, hex_f;

  assign hex_a = (HEX_MODE != 0) ? SEG_A : SEG_BLANK;
  assign hex_b = (HEX_MODE != 0) ? SEG_B : SEG_BLANK;
  assign hex_c = (HEX_MODE != 0) ? SEG_C : SEG_BLANK;
  assign hex_d = (HEX_MODE != 0) ? SEG_D : SEG_BLANK;
  assign hex_e = (HEX_MODE != 0) ? SEG_E : SEG_BLANK;
  assign hex_f = (HEX_MODE != 0) ? SEG_F : SEG_BLANK;

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (code_i)
        4'h0: seg_o = SEG_0;
        4'h1: seg_o = SEG_1;
        4'h2: seg_o = SEG_2;
        4'h3: seg_o = SEG_3;
        4'h4: seg_o = SEG_4;
        4'h5: seg_o = SEG_5;
        4'h6: seg_o = SEG_6;
        4'h7: seg_o = SEG_7;
        4'h8: seg_o = SEG_8;
        4'h9: seg_o = SEG_9;
        4'hA: seg_o = hex_a;
        4'hB: seg_o = hex_b;
        4'hC: seg_o = hex_c;
        4'hD: seg_o = hex_d;
        4'hE: seg_o = hex_e;
        4'hF: seg_o = hex_f;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner: prescaled digit index, frame-aligned
// shadow of the input value, leading-zero blanking and registered pin outputs.
module seven_segment_scanner
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int HEX_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  seven_segment_scanner_if.slave  disp
);

  localparam int CW = cnt_width(SCAN_DIV);
  localparam int IW = cnt_width(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    load_pending_q, load_pending_d;
  logic [NUM_DIGITS-1:0]   digit_q, digit_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    tick_q, tick_d;

  logic                  tick, wrap, load;
  logic [3:0]            sel_nib;
  logic                  sel_dp, sel_zero, sel_blank;
  logic [NUM_DIGITS:0]   zero_from;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            dec_seg;

  assign tick = disp.enable && (cnt_q == CNT_LAST);
  assign wrap = tick && (idx_q == IDX_LAST);
  assign load = disp.enable && (load_pending_q || wrap);

  always_comb begin
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    shadow_val_d   = shadow_val_q;
    shadow_dp_d    = shadow_dp_q;
    load_pending_d = load_pending_q;
    if (disp.enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end
    if (load) begin
      shadow_val_d   = disp.value;
      shadow_dp_d    = disp.dp_mask;
      load_pending_d = 1'b0;
    end
  end

  // zero_from[i] is set when shadow nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    zero_from             = '0;
    zero_from[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (shadow_val_q[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    sel_nib  = '0;
    sel_dp   = 1'b0;
    sel_zero = 1'b0;
    onehot   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib   = shadow_val_q[4*i +: 4];
        sel_dp    = shadow_dp_q[i];
        sel_zero  = zero_from[i];
        onehot[i] = 1'b1;
      end
    end
  end

  assign sel_blank = disp.blank_lz && (idx_q != '0) && sel_zero;

  seg7_hex_decoder #(
    .HEX_MODE (HEX_MODE)
  ) u_dec (
    .code_i  (sel_nib),
    .blank_i (sel_blank),
    .seg_o   (dec_seg)
  );

  always_comb begin
    digit_d = '1;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    tick_d  = tick;
    if (disp.enable) begin
      digit_d = ~onehot;
      seg_d   = dec_seg;
      dp_d    = ~sel_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      shadow_val_q   <= '0;
      shadow_dp_q    <= '0;
      load_pending_q <= 1'b1;
      digit_q        <= '1;
      seg_q          <= SEG_BLANK;
      dp_q           <= 1'b1;
      tick_q         <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      shadow_val_q   <= shadow_val_d;
      shadow_dp_q    <= shadow_dp_d;
      load_pending_q <= load_pending_d;
      digit_q        <= digit_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      tick_q         <= tick_d;
    end
  end

  assign disp.DIGIT       = digit_q;
  assign disp.DISPLAY_OUT = seg_q;
  assign disp.DP_OUT      = dp_q;
  assign disp.scan_tick   = tick_q;

endmodule
